// File: rtl/ram_dp_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM (one write port,
// one read port with 2-cycle read latency). Each RAM port is arbitrated
// independently by round-robin. A read that hits the address of a write
// accepted in the same cycle is held off one cycle so it returns new data.
module ram_dp_arbiter #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 1024,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_we,
  input  logic [2*AW-1:0]        req_addr,
  input  logic [2*RAM_WIDTH-1:0] req_wdata,
  input  logic [2*RAM_WIDTH-1:0] req_wmask,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [RAM_WIDTH-1:0]   rsp_data,
  output logic [AW-1:0]          ram_addr_wr,
  output logic [AW-1:0]          ram_addr_rd,
  output logic [RAM_WIDTH-1:0]   ram_data_in,
  output logic [RAM_WIDTH-1:0]   ram_enb_wr,
  input  logic [RAM_WIDTH-1:0]   ram_data_out
);

  // Per-requester views of the packed command buses.
  logic [AW-1:0]        addr_slice  [2];
  logic [RAM_WIDTH-1:0] wdata_slice [2];
  logic [RAM_WIDTH-1:0] wmask_slice [2];

  // Arbitration state: id of the requester granted last on each port.
  logic wr_last_reg;
  logic rd_last_reg;

  // Read response tag pipeline (valid + requester id), two stages deep to
  // line up with the RAM read latency.
  logic s1_valid_reg;
  logic s1_id_reg;
  logic s2_valid_reg;
  logic s2_id_reg;

  logic [1:0]    wr_cand;
  logic [1:0]    wr_gnt;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [1:0]    rd_conflict;
  logic [1:0]    rd_cand;
  logic [1:0]    rd_gnt;
  logic          rd_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign addr_slice[gi]  = req_addr[gi*AW +: AW];
      assign wdata_slice[gi] = req_wdata[gi*RAM_WIDTH +: RAM_WIDTH];
      assign wmask_slice[gi] = req_wmask[gi*RAM_WIDTH +: RAM_WIDTH];
      // A read colliding with this cycle's accepted write must wait a cycle.
      assign rd_conflict[gi] = (|wr_gnt) && (addr_slice[gi] == wr_addr);
    end
  endgenerate

  // Write port round-robin: under contention, grant the requester not granted last.
  always_comb begin
    wr_cand = req_valid & req_we;
    wr_gnt  = wr_cand;
    if (wr_cand == 2'b11) begin
      wr_gnt = wr_last_reg ? 2'b01 : 2'b10;
    end
    wr_sel  = wr_gnt[1];
    wr_addr = addr_slice[wr_sel];
  end

  // Read port round-robin among reads not blocked by a same-address write.
  always_comb begin
    rd_cand = req_valid & ~req_we & ~rd_conflict;
    rd_gnt  = rd_cand;
    if (rd_cand == 2'b11) begin
      rd_gnt = rd_last_reg ? 2'b01 : 2'b10;
    end
    rd_sel = rd_gnt[1];
  end

  // RAM-side drive and handshake; everything is held quiet during reset.
  always_comb begin
    req_ready   = rst_n ? (wr_gnt | rd_gnt) : 2'b00;
    ram_addr_wr = wr_addr;
    ram_data_in = wdata_slice[wr_sel];
    ram_enb_wr  = (rst_n && (|wr_gnt)) ? wmask_slice[wr_sel] : '0;
    ram_addr_rd = addr_slice[rd_sel];
    rsp_valid   = {s2_valid_reg & s2_id_reg, s2_valid_reg & ~s2_id_reg};
    rsp_data    = ram_data_out;
  end

  // Priority pointers remember the last granted id; reset favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last_reg <= 1'b1;
      rd_last_reg <= 1'b1;
    end else begin
      if (|wr_gnt) wr_last_reg <= wr_sel;
      if (|rd_gnt) rd_last_reg <= rd_sel;
    end
  end

  // Tag pipeline carrying each accepted read to its response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_id_reg    <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_id_reg    <= 1'b0;
    end else begin
      s1_valid_reg <= |rd_gnt;
      s1_id_reg    <= rd_sel;
      s2_valid_reg <= s1_valid_reg;
      s2_id_reg    <= s1_id_reg;
    end
  end

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Directed bench for ram_dp_arbiter with a behavioural 2-cycle-latency RAM.
module tb_ram_dp_arbiter;
  localparam int W  = 8;
  localparam int D  = 1024;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*W-1:0]  req_wdata;
  logic [2*W-1:0]  req_wmask;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [W-1:0]    rsp_data;
  logic [AW-1:0]   ram_addr_wr;
  logic [AW-1:0]   ram_addr_rd;
  logic [W-1:0]    ram_data_in;
  logic [W-1:0]    ram_enb_wr;
  logic [W-1:0]    ram_data_out;

  int checks = 0;
  int failures = 0;

  ram_dp_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
    .ram_data_in(ram_data_in), .ram_enb_wr(ram_enb_wr),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: per-bit masked write, read data two cycles after address.
  logic [W-1:0] mem [D];
  logic [W-1:0] rd_q1;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      mem[ram_addr_wr] <= (mem[ram_addr_wr] & ~ram_enb_wr) | (ram_data_in & ram_enb_wr);
    end
    rd_q1        <= mem[ram_addr_rd];
    ram_data_out <= rd_q1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] m0, input logic [W-1:0] m1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    req_wmask = {m1, m0};
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b11, 2'b11, 10'd5, 10'd5, 8'hAA, 8'h55, 8'hFF, 8'hFF);
    next_cycle();
    drive(2'b11, 2'b11, 10'd5, 10'd5, 8'hAA, 8'h55, 8'hFF, 8'hFF);
    check("reset_ready", {30'd0, req_ready}, 32'h0);
    check("reset_enb", {24'd0, ram_enb_wr}, 32'h0);
    check("reset_rsp", {30'd0, rsp_valid}, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // Both write addr 5: first contention goes to requester 0, then 1.
    drive(2'b11, 2'b11, 10'd5, 10'd5, 8'hAA, 8'h55, 8'hFF, 8'hFF);
    $display("txn: both write addr5 cycle1 ready=%b enb=%h data=%h", req_ready, ram_enb_wr, ram_data_in);
    check("wr_cont1_ready", {30'd0, req_ready}, 32'h1);
    check("wr_cont1_enb", {24'd0, ram_enb_wr}, 32'hFF);
    check("wr_cont1_data", {24'd0, ram_data_in}, 32'hAA);
    check("wr_cont1_addr", {22'd0, ram_addr_wr}, 32'h5);
    next_cycle();
    drive(2'b11, 2'b11, 10'd5, 10'd5, 8'hAA, 8'h55, 8'hFF, 8'hFF);
    $display("txn: both write addr5 cycle2 ready=%b data=%h", req_ready, ram_data_in);
    check("wr_cont2_ready", {30'd0, req_ready}, 32'h2);
    check("wr_cont2_data", {24'd0, ram_data_in}, 32'h55);
    next_cycle();

    // Write addr 3 by req0 with read addr 3 by req1: read waits one cycle.
    drive(2'b11, 2'b01, 10'd3, 10'd3, 8'h3C, 8'h00, 8'hFF, 8'h00);
    $display("txn: wr3 + rd3 same cycle ready=%b", req_ready);
    check("hazard_ready", {30'd0, req_ready}, 32'h1);
    check("hazard_enb", {24'd0, ram_enb_wr}, 32'hFF);
    next_cycle();
    drive(2'b10, 2'b00, 10'd0, 10'd3, 8'h00, 8'h00, 8'h00, 8'h00);
    $display("txn: rd3 retry ready=%b addr_rd=%0d", req_ready, ram_addr_rd);
    check("hazard_retry_ready", {30'd0, req_ready}, 32'h2);
    check("hazard_retry_addr", {22'd0, ram_addr_rd}, 32'h3);
    next_cycle();
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("hazard_rsp_n1", {30'd0, rsp_valid}, 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    $display("txn: rd3 response rsp_valid=%b data=%h", rsp_valid, rsp_data);
    check("hazard_rsp_valid", {30'd0, rsp_valid}, 32'h2);
    check("hazard_rsp_data", {24'd0, rsp_data}, 32'h3C);
    next_cycle();

    // Both read continuously: req0 addr 5 (0x55), req1 addr 3 (0x3C).
    begin
      logic [1:0] exp_gnt [10];
      for (int k = 0; k < 10; k++) begin
        exp_gnt[k] = (k >= 8) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      end
      for (int k = 0; k < 11; k++) begin
        if (k < 8) drive(2'b11, 2'b00, 10'd5, 10'd3, 8'h00, 8'h00, 8'h00, 8'h00);
        else       drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        $display("txn: stream cycle %0d ready=%b rsp_valid=%b rsp_data=%h", k, req_ready, rsp_valid, rsp_data);
        if (k < 10) check($sformatf("stream_ready_%0d", k), {30'd0, req_ready}, {30'd0, exp_gnt[k]});
        if (k >= 2) begin
          check($sformatf("stream_rsp_%0d", k), {30'd0, rsp_valid}, {30'd0, exp_gnt[k-2]});
          if (exp_gnt[k-2] != 2'b00)
            check($sformatf("stream_data_%0d", k), {24'd0, rsp_data},
                  (exp_gnt[k-2] == 2'b01) ? 32'h55 : 32'h3C);
        end
        next_cycle();
      end
    end

    // Masked write: only low nibble of 0xFF lands over 0x00.
    drive(2'b01, 2'b01, 10'd7, 10'd0, 8'hFF, 8'h00, 8'h0F, 8'h00);
    $display("txn: masked write addr7 enb=%h", ram_enb_wr);
    check("mask_enb", {24'd0, ram_enb_wr}, 32'h0F);
    next_cycle();
    drive(2'b01, 2'b00, 10'd7, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("mask_rd_ready", {30'd0, req_ready}, 32'h1);
    next_cycle();
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    next_cycle();
    $display("txn: masked read addr7 rsp_valid=%b data=%h", rsp_valid, rsp_data);
    check("mask_rsp_valid", {30'd0, rsp_valid}, 32'h1);
    check("mask_rsp_data", {24'd0, rsp_data}, 32'h0F);
    next_cycle();

    // Read in flight killed by reset; pointers return to favour requester 0.
    drive(2'b10, 2'b00, 10'd0, 10'd3, 8'h00, 8'h00, 8'h00, 8'h00);
    check("flush_rd_ready", {30'd0, req_ready}, 32'h2);
    next_cycle();
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 10'd5, 10'd3, 8'h00, 8'h00, 8'h00, 8'h00);
    check("flush_reset_ready", {30'd0, req_ready}, 32'h0);
    check("flush_reset_rsp", {30'd0, rsp_valid}, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    $display("txn: after reset pulse rsp_valid=%b", rsp_valid);
    check("flush_after_rsp", {30'd0, rsp_valid}, 32'h0);
    next_cycle();
    drive(2'b11, 2'b11, 10'd9, 10'd9, 8'h11, 8'h22, 8'hFF, 8'hFF);
    $display("txn: post-reset write contention ready=%b", req_ready);
    check("post_reset_wr_ready", {30'd0, req_ready}, 32'h1);
    next_cycle();
    drive(2'b11, 2'b00, 10'd5, 10'd3, 8'h00, 8'h00, 8'h00, 8'h00);
    $display("txn: post-reset read contention ready=%b", req_ready);
    check("post_reset_rd_ready", {30'd0, req_ready}, 32'h1);
    next_cycle();
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_dp_arbiter.md
RAM_DP_ARBITER -- requirements
Module: ram_dp_arbiter

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter RAM_DEPTH, default 1024, word count; AW = $clog2(RAM_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  2  bit i: requester i presents a command.
REQ-006 SHALL have port req_we  input  2  bit i: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  2*AW  requester i address at bits [i*AW +: AW].
REQ-008 SHALL have port req_wdata  input  2*RAM_WIDTH  requester i write data, slice i.
REQ-009 SHALL have port req_wmask  input  2*RAM_WIDTH  requester i per-bit write enable, slice i.
REQ-010 SHALL have port req_ready  output  2  bit i: command of requester i accepted this cycle.
REQ-011 SHALL have port rsp_valid  output  2  bit i: rsp_data holds read data for requester i; at most one bit set.
REQ-012 SHALL have port rsp_data  output  RAM_WIDTH  read response data.
REQ-013 SHALL have port ram_addr_wr  output  AW  to RAM write address.
REQ-014 SHALL have port ram_addr_rd  output  AW  to RAM read address.
REQ-015 SHALL have port ram_data_in  output  RAM_WIDTH  to RAM write data.
REQ-016 SHALL have port ram_enb_wr  output  RAM_WIDTH  to RAM per-bit write enable.
REQ-017 SHALL have port ram_data_out  input  RAM_WIDTH  from RAM; valid 2 cycles after read address presented.

Function
REQ-018 SHALL arbitrate the write port and read port independently; one write and one read may be granted in the same cycle (different requesters).
REQ-019 SHALL grant per port by round-robin: when both requesters contend, grant the one not granted last on that port; single contender always granted.
REQ-020 SHALL drive req_ready combinationally from current req_valid/req_we/req_addr and registered priority pointers; accept = req_valid & req_ready.
REQ-021 SHALL drive ram_enb_wr = granted requester's wmask when a write is accepted, else all zeros; ram_addr_wr/ram_data_in follow granted requester (don't-care otherwise).
REQ-022 SHALL drive ram_addr_rd with the accepted read's address (don't-care when none).
REQ-023 SHALL withhold read grant (ready low) when the read address equals the address of a write accepted the same cycle; read is granted next cycle and returns new data.
REQ-024 SHALL, for a read accepted in cycle N, assert rsp_valid[id] in cycle N+2 only, with rsp_data = ram_data_out, via a 2-stage valid/id tag pipeline.
REQ-025 SHALL sustain one read acceptance per cycle; responses are not backpressurable.
REQ-026 SHALL update a port's priority pointer only on cycles where that port grants under contention or single request (pointer = last granted id).
REQ-027 SHALL pass rsp_data = ram_data_out unconditionally; consumers qualify with rsp_valid.

Reset
REQ-028 SHALL, while rst_n low, force rsp_valid = 0, tag pipeline cleared, both priority pointers set so requester 0 wins first contention.
REQ-029 SHALL hold ram_enb_wr = 0 and req_ready = 0 while rst_n low; reads in flight at reset assertion produce no response.

Verification
REQ-030 SHALL cover: both write to addr 5, data 0xAA/0x55, mask 0xFF, first contention after reset -> cycle 1 ready=01, enb_wr=0xFF data 0xAA; cycle 2 ready=10 data 0x55.
REQ-031 SHALL cover: req0 write addr 3 data 0x3C mask 0xFF, req1 read addr 3 same cycle -> ready=01; next cycle ready=10; rsp_valid=10 with rsp_data=0x3C two cycles after read grant.
REQ-032 SHALL cover: req0 write addr 7 mask 0x0F data 0xFF over stored 0x00 -> later read returns 0x0F.
REQ-033 SHALL cover: both read continuously 8 cycles -> grants alternate 01,10,...; rsp_valid follows grants with exactly 2-cycle latency, no gaps.
REQ-034 SHALL cover: read accepted in cycle N, rst_n pulsed low in N+1 -> rsp_valid stays 00; after release, first contention granted to requester 0.
